// File: rtl/apb3_slave_regbank.sv
// APB3 completer: word-addressed register bank with fixed wait states and PSLVERR
// on unaligned or out-of-range addresses. All outputs are registered.
module apb3_slave_regbank #(
    parameter int DEPTH       = 48,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  paddr,
    input  logic        pwrite,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [31:0] mem [DEPTH];
    logic [5:0]  idx_q;
    logic        write_q, err_q;
    logic [31:0] wdata_q;
    logic [3:0]  cnt_q;

    logic        setup, complete, abort, ready_set;
    logic        err_in, cur_err, cur_write;
    logic [5:0]  cur_idx;

    assign err_in = (paddr[1:0] != 2'b00) || ({1'b0, paddr[7:2]} >= 7'(DEPTH));

    // With zero wait states pready is raised on the SETUP edge itself, so the
    // response path must see the live bus rather than the latched copy.
    assign cur_idx   = setup ? paddr[7:2] : idx_q;
    assign cur_err   = setup ? err_in     : err_q;
    assign cur_write = setup ? pwrite     : write_q;

    always_comb begin
        state_d   = state_q;
        setup     = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        ready_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    setup     = 1'b1;
                    state_d   = ACCESS;
                    ready_set = (WAIT_CYCLES == 0);
                end
            end
            ACCESS: begin
                if (!psel) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (penable && pready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (!pready && cnt_q <= 4'd1) begin
                    ready_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;

            if (setup) begin
                idx_q   <= paddr[7:2];
                write_q <= pwrite;
                err_q   <= err_in;
                wdata_q <= pwdata;
                cnt_q   <= 4'(WAIT_CYCLES);
            end else if (state_q == ACCESS && psel && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (ready_set) begin
                pready  <= 1'b1;
                pslverr <= cur_err;
                prdata  <= (!cur_write && !cur_err) ? mem[cur_idx] : 32'h0;
            end else if (complete || abort) begin
                pready  <= 1'b0;
                pslverr <= 1'b0;
                prdata  <= '0;
            end

            if (complete && write_q && !err_q) mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb3_slave_regbank.sv
// Directed bench for apb3_slave_regbank: two instances (0 and 3 wait states) driven
// through one bus task, with a scoreboard queue of expected responses.
module tb_apb3_slave_regbank;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  paddr;
    logic        pwrite, penable;
    logic        psel0, psel3;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [2][64];

    always #5 clk = ~clk;

    apb3_slave_regbank #(.DEPTH(48), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel0),
        .penable(penable), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
        .pslverr(pslverr0)
    );

    apb3_slave_regbank #(.DEPTH(48), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel3),
        .penable(penable), .pwdata(pwdata), .prdata(prdata3), .pready(pready3),
        .pslverr(pslverr3)
    );

    function automatic logic rdy(input int d);
        return (d == 0) ? pready0 : pready3;
    endfunction

    function automatic logic slv(input int d);
        return (d == 0) ? pslverr0 : pslverr3;
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? prdata0 : prdata3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transfer on instance d (0 -> 0 wait states, 1 -> 3 wait states).
    // Address and data are scrambled during ACCESS to prove they were captured in SETUP.
    task automatic xfer(input int d, input bit w, input logic [7:0] a, input logic [31:0] wd);
        exp_t e;
        int   waits;
        e.err  = (a[1:0] != 2'b00) || (a[7:2] >= 6'd48);
        e.rd   = !w;
        e.data = (w || e.err) ? 32'h0 : model[d][a[7:2]];
        if (w && !e.err) model[d][a[7:2]] = wd;
        sb.push_back(e);

        @(negedge clk);
        psel0 = (d == 0); psel3 = (d == 1);
        penable = 1'b0; pwrite = w; paddr = a; pwdata = wd;
        check("setup_pready_low", {31'h0, rdy(d)}, 32'h0);
        check("setup_prdata_zero", rdat(d), 32'h0);

        @(negedge clk);
        penable = 1'b1; paddr = ~a; pwdata = ~wd;
        waits = 0;
        while (!rdy(d) && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("wait_states", waits, (d == 0) ? 0 : 3);

        e = sb.pop_front();
        check("pslverr", {31'h0, slv(d)}, {31'h0, e.err});
        if (e.rd) check("prdata", rdat(d), e.data);
    endtask

    task automatic go_idle(input int d);
        @(negedge clk);
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        check("idle_pready_low", {31'h0, rdy(d)}, 32'h0);
        check("idle_pslverr_low", {31'h0, slv(d)}, 32'h0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) model[d][i] = 32'h0;

        // Reset with garbage on the bus
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            paddr = 8'($urandom); pwrite = 1'($urandom); psel0 = 1'($urandom);
            psel3 = 1'($urandom); penable = 1'($urandom); pwdata = $urandom;
        end
        @(negedge clk);
        check("rst_prdata0", prdata0, 32'h0);
        check("rst_pready0", {31'h0, pready0}, 32'h0);
        check("rst_pslverr0", {31'h0, pslverr0}, 32'h0);
        check("rst_prdata3", prdata3, 32'h0);
        check("rst_pready3", {31'h0, pready3}, 32'h0);
        check("rst_pslverr3", {31'h0, pslverr3}, 32'h0);
        rst = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;

        xfer(0, 0, 8'h10, 32'h0);
        go_idle(0);

        // Zero wait states: write then back-to-back read
        xfer(0, 1, 8'h08, 32'hDEADBEEF);
        xfer(0, 0, 8'h08, 32'h0);
        go_idle(0);

        // Three wait states
        xfer(1, 1, 8'h04, 32'h12345678);
        xfer(1, 0, 8'h04, 32'h0);
        // Error decode: unaligned, out of range, then untouched word
        xfer(1, 1, 8'h05, 32'hFFFFFFFF);
        xfer(1, 1, 8'hC0, 32'hFFFFFFFF);
        xfer(1, 0, 8'h04, 32'h0);
        xfer(1, 0, 8'hC0, 32'h0);
        xfer(1, 0, 8'hBC, 32'h0);
        go_idle(1);

        // Abort: psel dropped in the 2nd ACCESS cycle
        @(negedge clk);
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hA5A5A5A5;
        @(negedge clk);
        penable = 1'b1;
        check("abort_acc1_pready", {31'h0, pready3}, 32'h0);
        @(negedge clk);
        check("abort_acc2_pready", {31'h0, pready3}, 32'h0);
        psel3 = 1'b0; penable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_after_pready", {31'h0, pready3}, 32'h0);
        end
        xfer(1, 0, 8'h0C, 32'h0);
        go_idle(1);

        // Stray penable without SETUP
        @(negedge clk);
        psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stray_pready", {31'h0, pready0}, 32'h0);
        end
        psel0 = 1'b0; penable = 1'b0;
        xfer(0, 0, 8'h08, 32'h0);
        go_idle(0);

        // Reset mid-transfer: outputs clear, no write lands
        @(negedge clk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 32'h55AA55AA;
        @(negedge clk);
        penable = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("midrst_pready", {31'h0, pready0}, 32'h0);
        check("midrst_prdata", prdata0, 32'h0);
        rst = 1'b0; psel0 = 1'b0; penable = 1'b0;
        model[0][2] = 32'h0;
        xfer(0, 0, 8'h20, 32'h0);
        xfer(0, 0, 8'h08, 32'h0);
        go_idle(0);

        check("scoreboard_empty", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
